// File: rtl/shreg_univ_edge.sv
// rtl/shreg_univ_edge.sv - universal shift register with an edge-selectable clock, a saturating shift counter and a full flag
module shreg_univ_edge #(
  parameter int               WIDTH    = 8,
  parameter bit               NEG_EDGE = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  localparam int              CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             full
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Clock polarity is fixed at elaboration, so the state still lives in one clocked block.
  logic active_clk;
  assign active_clk = NEG_EDGE ? ~clk : clk;

  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    cnt_nxt;
  logic             full_nxt;

  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_val = rot ? q : sin_r;
      assign shr_val = rot ? q : sin_l;
    end else begin : g_wn
      assign shl_val = {q[WIDTH-2:0], rot ? q[WIDTH-1] : sin_r};
      assign shr_val = {rot ? q[0] : sin_l, q[WIDTH-1:1]};
    end
  endgenerate

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    q_nxt    = q;
    cnt_nxt  = cnt;
    full_nxt = full;
    if (en) begin
      case (mode)
        MODE_SHL: begin
          q_nxt    = shl_val;
          cnt_nxt  = cnt_inc;
          full_nxt = (cnt_inc == CNT_MAX);
        end
        MODE_SHR: begin
          q_nxt    = shr_val;
          cnt_nxt  = cnt_inc;
          full_nxt = (cnt_inc == CNT_MAX);
        end
        MODE_LOAD: begin
          q_nxt    = d;
          cnt_nxt  = '0;
          full_nxt = 1'b0;
        end
        MODE_HOLD: begin
          q_nxt    = q;
        end
        default: begin
          q_nxt    = q;
        end
      endcase
    end
  end

  always_ff @(posedge active_clk) begin
    if (rst) begin
      q    <= RST_VAL;
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      q    <= q_nxt;
      cnt  <= cnt_nxt;
      full <= full_nxt;
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_shreg_univ_edge.sv
// tb/tb_shreg_univ_edge.sv - randomized and directed check of shreg_univ_edge against a behavioural model
module tb_shreg_univ_edge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b0, rot = 1'b0, sin_l = 1'b0, sin_r = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] d = 8'h00;

  logic [7:0] q_n, q_p;
  logic [3:0] cnt_n, cnt_p;
  logic       sl_n, sr_n, full_n, sl_p, sr_p, full_p;
  logic [0:0] q_1, cnt_1;
  logic       sl_1, sr_1, full_1;

  shreg_univ_edge #(.WIDTH(8), .NEG_EDGE(1'b1), .RST_VAL(8'h00)) u_neg (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .sin_l(sin_l), .sin_r(sin_r),
    .d(d), .q(q_n), .sout_l(sl_n), .sout_r(sr_n), .cnt(cnt_n), .full(full_n));

  shreg_univ_edge #(.WIDTH(8), .NEG_EDGE(1'b0), .RST_VAL(8'h00)) u_pos (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .sin_l(sin_l), .sin_r(sin_r),
    .d(d), .q(q_p), .sout_l(sl_p), .sout_r(sr_p), .cnt(cnt_p), .full(full_p));

  shreg_univ_edge #(.WIDTH(1), .NEG_EDGE(1'b0), .RST_VAL(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .sin_l(sin_l), .sin_r(sin_r),
    .d(d[0:0]), .q(q_1), .sout_l(sl_1), .sout_r(sr_1), .cnt(cnt_1), .full(full_1));

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 = u_neg, 1 = u_pos, 2 = u_w1
  int mq[3], mc[3], mf[3];
  bit mv[3];
  int mw[3] = '{8, 8, 1};
  int mr[3] = '{0, 0, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    int mask;
    int b;
    mask = (1 << mw[i]) - 1;
    if (rst) begin
      mq[i] = mr[i]; mc[i] = 0; mf[i] = 0; mv[i] = 1'b1;
    end else if (en && mv[i]) begin
      if (mode == 2'b01 || mode == 2'b10) begin
        if (mode == 2'b01) begin
          b = rot ? ((mq[i] >> (mw[i] - 1)) & 1) : int'(sin_r);
          mq[i] = ((mq[i] << 1) | b) & mask;
        end else begin
          b = rot ? (mq[i] & 1) : int'(sin_l);
          mq[i] = (mq[i] >> 1) | (b << (mw[i] - 1));
        end
        mc[i] = (mc[i] < mw[i]) ? mc[i] + 1 : mw[i];
        mf[i] = (mc[i] == mw[i]) ? 1 : 0;
      end else if (mode == 2'b11) begin
        mq[i] = int'(d) & mask; mc[i] = 0; mf[i] = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step(0);
      #1;
      if (mv[0]) begin
        chk("neg_q", q_n, mq[0]);
        chk("neg_sout_l", sl_n, (mq[0] >> 7) & 1);
        chk("neg_sout_r", sr_n, mq[0] & 1);
        chk("neg_cnt", cnt_n, mc[0]);
        chk("neg_full", full_n, mf[0]);
      end
      @(posedge clk);
      model_step(1);
      model_step(2);
      #1;
      if (mv[1]) begin
        chk("pos_q", q_p, mq[1]);
        chk("pos_sout_l", sl_p, (mq[1] >> 7) & 1);
        chk("pos_sout_r", sr_p, mq[1] & 1);
        chk("pos_cnt", cnt_p, mc[1]);
        chk("pos_full", full_p, mf[1]);
      end
      if (mv[2]) begin
        chk("w1_q", q_1, mq[2]);
        chk("w1_sout", {sl_1, sr_1}, {mq[2][0], mq[2][0]});
        chk("w1_cnt", cnt_1, mc[2]);
        chk("w1_full", full_1, mf[2]);
      end
    end
  end

  // Inputs change between edges so every vector spans one falling then one rising edge.
  task automatic step(input bit r, input bit e, input bit [1:0] m, input bit ro,
                      input bit a, input bit b, input bit [7:0] dd);
    @(posedge clk);
    #2;
    rst = r; en = e; mode = m; rot = ro; sin_l = a; sin_r = b; d = dd;
    @(negedge clk);
    #2;
  endtask

  initial begin
    step(1, 0, 2'b00, 0, 0, 0, 8'h00);
    chk("reset_q", q_n, 8'h00);
    chk("reset_cnt", cnt_n, 0);
    chk("reset_full", full_n, 0);

    // Reset held across a rising edge only takes effect on the falling edge
    step(0, 1, 2'b11, 0, 0, 0, 8'hFF);
    step(0, 1, 2'b01, 0, 0, 1, 8'h00);
    chk("pre_rst_cnt", cnt_n, 1);
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    chk("rst_rising_q", q_n, 8'hFF);
    @(negedge clk); #2;
    chk("rst_falling_q", q_n, 8'h00);
    chk("rst_falling_cnt", cnt_n, 0);
    chk("rst_falling_full", full_n, 0);

    step(0, 1, 2'b11, 0, 0, 0, 8'hA5);
    chk("load_a5", q_n, 8'hA5);
    repeat (3) begin
      step(0, 0, 2'b01, 0, 1, 1, 8'h00);
      chk("en0_q", q_n, 8'hA5);
      chk("en0_cnt", cnt_n, 0);
    end

    step(0, 1, 2'b01, 0, 0, 1, 8'h00);
    chk("shl_4b", q_n, 8'h4B);
    chk("shl_sout", {sl_n, sr_n}, 2'b01);
    step(0, 1, 2'b11, 0, 0, 0, 8'hA5);
    step(0, 1, 2'b10, 0, 0, 1, 8'h00);
    chk("shr_52", q_n, 8'h52);
    chk("shr_sout", {sl_n, sr_n}, 2'b00);

    step(0, 1, 2'b11, 1, 0, 0, 8'h81);
    step(0, 1, 2'b01, 1, 1, 0, 8'h00);
    chk("rotl_03", q_n, 8'h03);
    step(0, 1, 2'b11, 1, 0, 0, 8'h81);
    step(0, 1, 2'b10, 1, 0, 1, 8'h00);
    chk("rotr_c0", q_n, 8'hC0);

    step(0, 1, 2'b11, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, 2'b01, 0, 0, 1'($urandom), 8'h00);
      chk("sat_cnt", cnt_n, (i > 8) ? 8 : i);
      chk("sat_full", full_n, (i >= 8) ? 1 : 0);
    end
    step(0, 1, 2'b11, 0, 0, 0, 8'h5A);
    chk("reload_cnt", cnt_n, 0);
    chk("reload_full", full_n, 0);

    // Reset wins over a simultaneous load on every variant
    step(1, 1, 2'b11, 0, 0, 0, 8'h3C);
    chk("rst_vs_load_neg", q_n, 8'h00);
    @(posedge clk); #1;
    chk("rst_vs_load_pos", q_p, 8'h00);
    chk("rst_val_w1", q_1, 1);
    step(0, 1, 2'b11, 0, 0, 0, 8'h3C);
    chk("pos_no_fall_update", q_p, 8'h00);
    @(posedge clk); #1;
    chk("pos_load_3c", q_p, 8'h3C);
    chk("w1_load", q_1, 0);
    step(0, 1, 2'b01, 0, 0, 1, 8'h00);
    @(posedge clk); #1;
    chk("w1_shl_q", q_1, 1);
    chk("w1_full", full_1, 1);

    for (int n = 0; n < 400; n++) begin
      step(($urandom % 32) == 0, ($urandom % 4) != 0, 2'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom));
    end

    repeat (2) @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
